// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction sequencer.
//   - vend_state_e : sequencer states
//   - SC_*         : coarse state codes shared with the selection/cancel logic
//   - DEF_TIMEOUT_CYC : default PAY inactivity limit in cycles
//   - state_code_of() : maps a sequencer state onto its coarse code
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    PAY      = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4,
    REFUND   = 3'd5
  } vend_state_e;

  localparam logic [1:0] SC_SELECT = 2'b00;
  localparam logic [1:0] SC_PAY    = 2'b01;
  localparam logic [1:0] SC_CANCEL = 2'b11;

  localparam int DEF_TIMEOUT_CYC = 40;

  // Code 2'b10 is never produced.
  function automatic logic [1:0] state_code_of(input vend_state_e s);
    logic [1:0] code;
    case (s)
      PAY, DISPENSE, CHANGE: code = SC_PAY;
      REFUND:                code = SC_CANCEL;
      default:               code = SC_SELECT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/vend_credit_acc.sv
// Saturating credit accumulator plus PAY inactivity timer.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : clear credit and timer on the next edge
//   add_en/add_val: add a coin this cycle (saturates at all-ones)
//   cnt_en        : timer runs this cycle (asserted only while in PAY);
//                   when low the timer is held at zero
//   credit        : registered credit
//   credit_nxt    : credit including this cycle's coin (for same-cycle compare)
//   timeout       : this cycle brings the timer to TIMEOUT_CYC
module vend_credit_acc #(
  parameter int AMT_W       = 8,
  parameter int TIMEOUT_CYC = vend_pkg::DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [AMT_W-1:0] add_val,
  input  logic             cnt_en,
  output logic [AMT_W-1:0] credit,
  output logic [AMT_W-1:0] credit_nxt,
  output logic             timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [AMT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] timer_nxt;
  logic [AMT_W:0]   sum;
  logic [AMT_W-1:0] sum_sat;

  always_comb begin
    sum     = {1'b0, credit_q} + {1'b0, add_val};
    // Carry out means the true sum exceeds the representable range.
    sum_sat = sum[AMT_W] ? {AMT_W{1'b1}} : sum[AMT_W-1:0];

    credit_nxt = add_en ? sum_sat : credit_q;
    timer_nxt  = add_en ? '0 : timer_q + TMR_W'(1);
    timeout    = cnt_en && (timer_nxt == TMR_W'(TIMEOUT_CYC));

    credit_d = clr ? '0 : credit_nxt;
    // Outside PAY the timer sits at zero so every PAY visit starts fresh.
    timer_d  = (clr || !cnt_en) ? '0 : timer_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= '0;
      timer_q  <= '0;
    end else begin
      credit_q <= credit_d;
      timer_q  <= timer_d;
    end
  end

  assign credit = credit_q;

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer:
//   selection -> inventory lookup -> coin accumulation -> dispense -> change,
//   with cancel and inactivity-timeout refund paths.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   sel_valid/sel_index        : product selection pulse and index
//   coin_valid/coin_value      : coin insertion pulse and amount
//   cancel                     : user cancel level
//   inv_req/inv_index          : four-phase inventory lookup request
//   inv_ack/inv_avail/inv_price: lookup response
//   disp_req/disp_done         : four-phase dispense handshake
//   change_valid/change_amt    : change or refund pulse and amount
//   out_of_stock               : pulse when the selected item is unavailable
//   state_code                 : registered coarse state (00/01/11)
// All outputs are registered.
module vend_controller
  import vend_pkg::*;
#(
  parameter int IDX_W       = 4,
  parameter int AMT_W       = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel_index,
  input  logic             coin_valid,
  input  logic [AMT_W-1:0] coin_value,
  input  logic             cancel,
  output logic             inv_req,
  output logic [IDX_W-1:0] inv_index,
  input  logic             inv_ack,
  input  logic             inv_avail,
  input  logic [AMT_W-1:0] inv_price,
  output logic             disp_req,
  input  logic             disp_done,
  output logic             change_valid,
  output logic [AMT_W-1:0] change_amt,
  output logic             out_of_stock,
  output logic [1:0]       state_code
);

  vend_state_e      state_q, state_d;
  // Set once the far side has acknowledged; we then wait for its ack to drop.
  logic             hs_seen_q, hs_seen_d;
  logic             avail_q, avail_d;
  logic [AMT_W-1:0] price_q, price_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             inv_req_q, inv_req_d;
  logic             disp_req_q, disp_req_d;
  logic             change_valid_q, change_valid_d;
  logic [AMT_W-1:0] change_amt_q, change_amt_d;
  logic             oos_q, oos_d;
  logic [1:0]       state_code_q, state_code_d;

  logic             acc_clr, acc_add, acc_cnt, acc_timeout;
  logic [AMT_W-1:0] credit, credit_nxt;

  vend_credit_acc #(
    .AMT_W      (AMT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clr       (acc_clr),
    .add_en    (acc_add),
    .add_val   (coin_value),
    .cnt_en    (acc_cnt),
    .credit    (credit),
    .credit_nxt(credit_nxt),
    .timeout   (acc_timeout)
  );

  always_comb begin
    state_d        = state_q;
    hs_seen_d      = hs_seen_q;
    avail_d        = avail_q;
    price_d        = price_q;
    idx_d          = idx_q;
    inv_req_d      = 1'b0;
    disp_req_d     = 1'b0;
    change_valid_d = 1'b0;
    change_amt_d   = '0;
    oos_d          = 1'b0;
    acc_clr        = 1'b0;
    acc_add        = 1'b0;
    acc_cnt        = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          idx_d     = sel_index;
          hs_seen_d = 1'b0;
          inv_req_d = 1'b1;
          state_d   = LOOKUP;
        end
      end

      LOOKUP: begin
        if (!hs_seen_q) begin
          if (inv_ack) begin
            hs_seen_d = 1'b1;
            avail_d   = inv_avail;
            price_d   = inv_price;
          end else begin
            inv_req_d = 1'b1;
          end
        end else if (!inv_ack) begin
          // Handshake complete; act on the captured response.
          hs_seen_d = 1'b0;
          if (avail_q) begin
            state_d = PAY;
          end else begin
            oos_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end

      PAY: begin
        acc_cnt = 1'b1;
        acc_add = coin_valid;
        // Cancel/timeout outrank sufficient credit; the refund includes any
        // coin accepted in this same cycle.
        if (cancel || acc_timeout) begin
          state_d        = REFUND;
          change_valid_d = (credit_nxt != '0);
          change_amt_d   = credit_nxt;
        end else if (credit_nxt >= price_q) begin
          state_d    = DISPENSE;
          hs_seen_d  = 1'b0;
          disp_req_d = 1'b1;
        end
      end

      DISPENSE: begin
        if (!hs_seen_q) begin
          if (disp_done) begin
            hs_seen_d = 1'b1;
          end else begin
            disp_req_d = 1'b1;
          end
        end else if (!disp_done) begin
          hs_seen_d = 1'b0;
          state_d   = CHANGE;
          // Change pulse is launched here so it coincides with CHANGE.
          if (credit > price_q) begin
            change_valid_d = 1'b1;
            change_amt_d   = credit - price_q;
          end
        end
      end

      CHANGE: begin
        acc_clr = 1'b1;
        state_d = IDLE;
      end

      REFUND: begin
        acc_clr = 1'b1;
        state_d = IDLE;
      end

      default: begin
        acc_clr = 1'b1;
        state_d = IDLE;
      end
    endcase

    state_code_d = state_code_of(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      hs_seen_q      <= 1'b0;
      avail_q        <= 1'b0;
      price_q        <= '0;
      idx_q          <= '0;
      inv_req_q      <= 1'b0;
      disp_req_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      oos_q          <= 1'b0;
      state_code_q   <= SC_SELECT;
    end else begin
      state_q        <= state_d;
      hs_seen_q      <= hs_seen_d;
      avail_q        <= avail_d;
      price_q        <= price_d;
      idx_q          <= idx_d;
      inv_req_q      <= inv_req_d;
      disp_req_q     <= disp_req_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      oos_q          <= oos_d;
      state_code_q   <= state_code_d;
    end
  end

  assign inv_req      = inv_req_q;
  assign inv_index    = idx_q;
  assign disp_req     = disp_req_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign out_of_stock = oos_q;
  assign state_code   = state_code_q;

endmodule

// File: tb/tb_vend_controller.sv
// Randomized scoreboard bench for vend_controller. The driver computes each
// transaction's outcome from the vending rules (sum of coins with saturation,
// cancel/timeout refund, change = credit - price) and queues expected events;
// a monitor pops and compares whenever the DUT shows disp_req rising,
// out_of_stock or change_valid.
module tb_vend_controller;

  localparam int TMO = 40;
  localparam int K_OOS = 0, K_DISP = 1, K_CHG = 2, K_REF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_valid = 1'b0;
  logic [3:0] sel_index = '0;
  logic       coin_valid = 1'b0;
  logic [7:0] coin_value = '0;
  logic       cancel = 1'b0;
  logic       inv_req;
  logic [3:0] inv_index;
  logic       inv_ack = 1'b0;
  logic       inv_avail = 1'b0;
  logic [7:0] inv_price = '0;
  logic       disp_req;
  logic       disp_done = 1'b0;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       out_of_stock;
  logic [1:0] state_code;

  vend_controller dut (
    .clk(clk), .rst(rst),
    .sel_valid(sel_valid), .sel_index(sel_index),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel),
    .inv_req(inv_req), .inv_index(inv_index), .inv_ack(inv_ack),
    .inv_avail(inv_avail), .inv_price(inv_price),
    .disp_req(disp_req), .disp_done(disp_done),
    .change_valid(change_valid), .change_amt(change_amt),
    .out_of_stock(out_of_stock), .state_code(state_code)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int amt; } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  bit avail_tbl [16];
  int price_tbl [16];
  int cur_idx   = 0;
  bit disp_hold = 1'b0;
  int c_vals[$];
  int c_gaps[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic got(input int kind, input int amt);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_amt", amt, e.amt);
    end
  endtask

  // Inventory responder: four-phase, random latency, checks inv_index.
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        inv_ack = 1'b0;
        dly = 0;
      end else if (!inv_ack && inv_req) begin
        if (dly == 0) begin
          chk("inv_index", int'(inv_index), cur_idx);
          inv_ack   = 1'b1;
          inv_avail = avail_tbl[inv_index];
          inv_price = 8'(price_tbl[inv_index]);
          dly = int'($urandom_range(0, 3));
        end else dly--;
      end else if (inv_ack && !inv_req) begin
        if (dly == 0) begin
          inv_ack = 1'b0;
          dly = int'($urandom_range(0, 3));
        end else dly--;
      end
    end
  end

  // Dispenser responder.
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        disp_done = 1'b0;
        dly = 0;
      end else if (!disp_done && disp_req && !disp_hold) begin
        if (dly == 0) begin
          disp_done = 1'b1;
          dly = int'($urandom_range(0, 3));
        end else dly--;
      end else if (disp_done && !disp_req) begin
        if (dly == 0) begin
          disp_done = 1'b0;
          dly = int'($urandom_range(0, 4));
        end else dly--;
      end
    end
  end

  // Monitor.
  initial begin
    bit disp_prev;
    int sc_run;
    disp_prev = 1'b0;
    sc_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        disp_prev = 1'b0;
        sc_run = 0;
      end else begin
        if (disp_req && !disp_prev) got(K_DISP, 0);
        disp_prev = disp_req;
        if (out_of_stock) got(K_OOS, 0);
        if (change_valid) got((state_code == 2'b11) ? K_REF : K_CHG, int'(change_amt));
        if (state_code == 2'b11) sc_run++;
        else if (sc_run != 0) begin
          chk("refund_state_width", sc_run, 1);
          sc_run = 0;
        end
      end
    end
  end

  // One input cycle starting at a negedge; returns at the next negedge.
  task automatic drive(input bit s, input int si, input bit c, input int cv, input bit cn);
    sel_valid  = s;
    sel_index  = si[3:0];
    coin_valid = c;
    coin_value = cv[7:0];
    cancel     = cn;
    @(negedge clk);
    sel_valid  = 1'b0;
    sel_index  = '0;
    coin_valid = 1'b0;
    coin_value = '0;
    cancel     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic wait_sc(input logic [1:0] v, input int bound);
    int i;
    i = 0;
    while (state_code != v && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (state_code != v) chk("wait_state_code", int'(state_code), int'(v));
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  int txn_no = 0;

  // end_mode: 0 keep paying until enough, 1 cancel, 2 wait for timeout.
  task automatic run_txn(input int idx, input bit avail, input int price,
                         input bit cancel_last, input int end_mode);
    int    credit;
    bit    done;
    bit    cx;
    string res;
    avail_tbl[idx] = avail;
    price_tbl[idx] = price;
    cur_idx = idx;
    credit = 0;
    done = 1'b0;
    res = "none";
    drive(0, 0, 1, 5, 1);                     // coin+cancel in IDLE: ignored
    drive(1, idx, 0, 0, 0);                   // select
    drive(1, (idx + 1) % 16, 1, 10, 0);       // reselect+coin in LOOKUP: ignored
    if (!avail) begin
      exp_q.push_back('{K_OOS, 0});
      res = "out_of_stock";
      idle(15);
    end else begin
      wait_sc(2'b01, 50);
      foreach (c_vals[i]) begin
        if (done) break;
        if (c_gaps[i] >= TMO) begin
          if (credit > 0) exp_q.push_back('{K_REF, credit});
          res = "timeout_refund";
          done = 1'b1;
          idle(TMO + 2);
        end else begin
          idle(c_gaps[i]);
          cx = cancel_last && (i == c_vals.size() - 1);
          credit = sat_add(credit, c_vals[i]);
          if (cx) begin
            if (credit > 0) exp_q.push_back('{K_REF, credit});
            res = "cancel_refund";
            done = 1'b1;
          end else if (credit >= price) begin
            exp_q.push_back('{K_DISP, 0});
            if (credit > price) exp_q.push_back('{K_CHG, credit - price});
            res = "dispense";
            done = 1'b1;
          end
          drive(0, 0, 1, c_vals[i], cx);
        end
      end
      if (!done) begin
        if (end_mode == 1) begin
          idle(1);
          if (credit > 0) exp_q.push_back('{K_REF, credit});
          res = "cancel_refund";
          drive(0, 0, 0, 0, 1);
        end else if (end_mode == 2) begin
          if (credit > 0) exp_q.push_back('{K_REF, credit});
          res = "timeout_refund";
          idle(TMO + 2);
        end else begin
          while (!done) begin
            idle(1);
            credit = sat_add(credit, 25);
            if (credit >= price) begin
              exp_q.push_back('{K_DISP, 0});
              if (credit > price) exp_q.push_back('{K_CHG, credit - price});
              res = "dispense";
              done = 1'b1;
            end
            drive(0, 0, 1, 25, 0);
          end
        end
      end
      wait_sc(2'b00, 300);
    end
    idle(3);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("change_amt_idle", int'(change_amt), 0);
    $display("txn %0d: idx=%0d avail=%0d price=%0d coins=%0d credit=%0d result=%s",
             txn_no, idx, avail, price, c_vals.size(), credit, res);
    txn_no++;
  endtask

  task automatic set_coins2(input int n, input int v0, input int g0, input int v1, input int g1);
    c_vals.delete();
    c_gaps.delete();
    if (n > 0) begin c_vals.push_back(v0); c_gaps.push_back(g0); end
    if (n > 1) begin c_vals.push_back(v1); c_gaps.push_back(g1); end
  endtask

  initial begin
    int i;
    foreach (avail_tbl[k]) begin avail_tbl[k] = 1'b0; price_tbl[k] = 0; end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_inv_req", int'(inv_req), 0);
    chk("reset_disp_req", int'(disp_req), 0);
    chk("reset_change_valid", int'(change_valid), 0);
    chk("reset_change_amt", int'(change_amt), 0);
    chk("reset_out_of_stock", int'(out_of_stock), 0);
    chk("reset_state_code", int'(state_code), 0);
    rst = 1'b1;
    idle(2);

    // Directed scenarios.
    set_coins2(2, 25, 0, 25, 2);   run_txn(3, 1, 50, 0, 0);   // exact pay
    set_coins2(2, 25, 1, 25, 1);   run_txn(7, 1, 30, 0, 0);   // overpay
    set_coins2(0, 0, 0, 0, 0);     run_txn(9, 0, 40, 0, 0);   // out of stock
    set_coins2(1, 10, 0, 0, 0);    run_txn(3, 1, 50, 0, 2);   // timeout
    c_vals = '{20, 20, 10}; c_gaps = '{1, 1, 1};
    run_txn(4, 1, 50, 1, 0);                                  // coin+cancel
    set_coins2(2, 10, 0, 40, TMO - 1); run_txn(6, 1, 50, 0, 0); // just inside
    set_coins2(2, 10, 0, 40, TMO);     run_txn(6, 1, 50, 0, 0); // just expired
    set_coins2(2, 200, 0, 200, 1); run_txn(2, 1, 255, 0, 0);  // saturation
    set_coins2(0, 0, 0, 0, 0);     run_txn(8, 1, 60, 0, 1);   // cancel, no credit

    // Reset in the middle of DISPENSE.
    avail_tbl[5] = 1'b1; price_tbl[5] = 30; cur_idx = 5; disp_hold = 1'b1;
    drive(1, 5, 0, 0, 0);
    wait_sc(2'b01, 50);
    drive(0, 0, 1, 25, 0);
    exp_q.push_back('{K_DISP, 0});
    drive(0, 0, 1, 25, 0);
    i = 0;
    while (!disp_req && i < 10) begin @(negedge clk); i++; end
    chk("disp_req_before_reset", int'(disp_req), 1);
    idle(2);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_disp_req", int'(disp_req), 0);
    chk("mid_reset_state_code", int'(state_code), 0);
    chk("mid_reset_change_valid", int'(change_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    disp_hold = 1'b0;
    idle(10);
    chk("post_reset_queue", exp_q.size(), 0);
    exp_q.delete();
    set_coins2(2, 10, 0, 20, 1);   run_txn(5, 1, 30, 0, 0);   // credit was discarded

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      int idx, price, n, r;
      bit avail, cl;
      idx   = int'($urandom_range(0, 15));
      avail = ($urandom_range(0, 4) != 0);
      price = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(1, 200));
      n     = int'($urandom_range(0, 4));
      c_vals.delete();
      c_gaps.delete();
      for (int k = 0; k < n; k++) begin
        r = int'($urandom_range(0, 5));
        case (r)
          0: c_vals.push_back(5);
          1: c_vals.push_back(10);
          2: c_vals.push_back(25);
          3: c_vals.push_back(50);
          4: c_vals.push_back(100);
          default: c_vals.push_back(int'($urandom_range(1, 255)));
        endcase
        r = int'($urandom_range(0, 19));
        if (r == 0) c_gaps.push_back(TMO + int'($urandom_range(0, 2)));
        else if (r == 1) c_gaps.push_back(TMO - 1);
        else c_gaps.push_back(int'($urandom_range(0, 5)));
      end
      cl = ($urandom_range(0, 4) == 0);
      run_txn(idx, avail, price, cl, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
